data_io_fifo: RTL and testbench

//  Next-generation MiST io-controller download port. Receives the file stream (cmds 0x53/0x54/0x55) over SPI,

---
 rtl/data_io_fifo_if.sv | 15 +
 rtl/data_io_fifo.sv | 158 +++++++++++++++
 tb/tb_data_io_fifo.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/data_io_fifo_if.sv
// RAM write port of the download FIFO: a word with its byte address and byte enables,
// held by the master until the slave acknowledges it.
interface data_io_fifo_if #(
    parameter int DW = 8,
    parameter int AW = 25
);
    logic            wr;
    logic            wr_ack;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [DW/8-1:0] be;

    modport master (output wr, a, d, be, input wr_ack);
    modport slave  (input wr, a, d, be, output wr_ack);
endinterface

// File: rtl/data_io_fifo.sv
// io-controller SPI download port: oversamples the file stream in the core clock domain,
// packs bytes into DW-bit words and writes them to RAM through a small buffering FIFO.
module data_io_fifo #(
    parameter int            DW         = 8,
    parameter int            AW         = 25,
    parameter logic [AW-1:0] START_ADDR = '0,
    parameter int            FIFO_AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sck,
    input  logic          ss,
    input  logic          sdi,
    output logic          downloading,
    output logic [AW-1:0] size,
    output logic [7:0]    index,
    output logic          overflow,
    data_io_fifo_if.master ram
);
    localparam int BW    = DW / 8;
    localparam int LW    = (BW > 1) ? $clog2(BW) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
    } ent_t;

    logic [2:0]         sck_r;
    logic [1:0]         ss_r, sdi_r;
    logic               armed;
    logic [3:0]         cnt;
    logic [6:0]         sr;
    logic [7:0]         cmd;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      pack;
    logic [BW-1:0]      be_acc;
    logic               ending;
    ent_t               mem [DEPTH];
    logic [FIFO_AW-1:0] wp, rp;
    logic [FIFO_AW:0]   count;   // includes the word currently held on the RAM port

    logic          bit_evt, byte_evt, is_start, is_end, is_data, last;
    logic          push, push_ok, issue, release_w;
    logic [7:0]    shift;
    logic [LW-1:0] lane;
    logic [DW-1:0] pack_nxt;
    ent_t          push_ent;

    always_comb begin
        bit_evt   = armed && sck_r[1] && !sck_r[2] && !ss_r[1];
        shift     = {sr, sdi_r[1]};
        byte_evt  = bit_evt && cnt == 4'd15;
        is_start  = byte_evt && cmd == 8'h53 && shift[0];
        is_end    = byte_evt && cmd == 8'h53 && !shift[0];
        is_data   = byte_evt && cmd == 8'h54 && downloading;
        lane      = (BW > 1) ? size[LW-1:0] : '0;
        last      = (lane == LW'(BW - 1));
        pack_nxt  = pack;
        pack_nxt[int'(lane) * 8 +: 8] = shift;
        push      = 1'b0;
        push_ent  = '{a: addr, d: pack_nxt, be: '1};
        if (is_data && last)
            push = 1'b1;
        if (is_end && be_acc != '0) begin
            push     = 1'b1;
            push_ent = '{a: addr, d: pack, be: be_acc};
        end
        release_w = ram.wr && ram.wr_ack;
        push_ok   = push && (count != FULL || release_w);
        issue     = !ram.wr && count != '0 && !is_start;
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            mem[wp] <= push_ent;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_r <= '0; ss_r <= '0; sdi_r <= '0;
            armed <= 1'b0; cnt <= '0; sr <= '0; cmd <= '0;
            downloading <= 1'b0; size <= '0; index <= '0; overflow <= 1'b0;
            addr <= START_ADDR; pack <= '0; be_acc <= '0; ending <= 1'b0;
            wp <= '0; rp <= '0; count <= '0;
            ram.wr <= 1'b0; ram.a <= '0; ram.d <= '0; ram.be <= '0;
        end else begin
            sck_r <= {sck_r[1:0], sck};
            ss_r  <= {ss_r[0], ss};
            sdi_r <= {sdi_r[0], sdi};

            // a frame only starts once ss has been seen high, so a reset mid-byte stays deaf
            if (ss_r[1]) begin
                armed <= 1'b1;
                cnt   <= '0;
            end else if (bit_evt) begin
                sr  <= shift[6:0];
                if (cnt == 4'd7) cmd <= shift;
                cnt <= (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;
            end

            if (byte_evt && cmd == 8'h55)
                index <= shift;

            if (is_data) begin
                size <= size + AW'(1);
                if (last) begin
                    pack   <= '0;
                    be_acc <= '0;
                    addr   <= addr + AW'(BW);
                end else begin
                    pack   <= pack_nxt;
                    be_acc <= be_acc | (BW'(1) << lane);
                end
            end

            if (push && !push_ok)
                overflow <= 1'b1;

            if (is_end) begin
                pack   <= '0;
                be_acc <= '0;
                ending <= downloading;
            end else if (ending && count == '0 && !push && !ram.wr) begin
                downloading <= 1'b0;
                ending      <= 1'b0;
            end

            // a restart keeps only the in-flight word's slot so its ack still balances count
            if (is_start) begin
                wp          <= rp;
                count       <= {{FIFO_AW{1'b0}}, ram.wr && !ram.wr_ack};
                size        <= '0;
                addr        <= START_ADDR;
                overflow    <= 1'b0;
                pack        <= '0;
                be_acc      <= '0;
                downloading <= 1'b1;
                ending      <= 1'b0;
            end else begin
                if (push_ok) wp <= wp + FIFO_AW'(1);
                if (issue)   rp <= rp + FIFO_AW'(1);
                count <= count + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, release_w};
            end

            if (release_w) begin
                ram.wr <= 1'b0;
            end else if (issue) begin
                ram.wr <= 1'b1;
                ram.a  <= mem[rp].a;
                ram.d  <= mem[rp].d;
                ram.be <= mem[rp].be;
            end
        end
    end
endmodule

// File: tb/tb_data_io_fifo.sv
// Directed bench: one SPI stream drives an 8-bit and a 16-bit instance; expected RAM writes
// are queued as stimulus is sent and checked as each write appears.
module tb_data_io_fifo;
    logic clk = 1'b0, reset = 1'b1, sck = 1'b0, ss = 1'b1, sdi = 1'b0;
    logic ack_en = 1'b0;
    logic dl8, dl16, ov8, ov16;
    logic [24:0] size8, size16;
    logic [7:0] idx8, idx16;
    logic p8 = 1'b0, p16 = 1'b0;
    int nchk = 0, npass = 0;

    typedef struct {
        logic [24:0] a;
        logic [15:0] d;
        logic [15:0] dm;
        logic [1:0]  be;
    } exp_t;
    exp_t q8[$], q16[$];

    data_io_fifo_if #(.DW(8),  .AW(25)) ram8 ();
    data_io_fifo_if #(.DW(16), .AW(25)) ram16 ();

    data_io_fifo #(.DW(8), .AW(25), .START_ADDR(25'h0), .FIFO_AW(2)) u8 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl8), .size(size8), .index(idx8), .overflow(ov8), .ram(ram8));
    data_io_fifo #(.DW(16), .AW(25), .START_ADDR(25'h0), .FIFO_AW(2)) u16 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl16), .size(size16), .index(idx16), .overflow(ov16), .ram(ram16));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // write monitor and RAM model: ack one cycle after wr is first seen
    always @(negedge clk) begin
        exp_t e;
        if (ram8.wr && !p8) begin
            nchk++;
            assert (q8.size() > 0) npass++;
            else $error("FAIL u8_unexpected_wr got a=%0h d=%0h exp none", ram8.a, ram8.d);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("u8_a", 32'(ram8.a), 32'(e.a));
                chk("u8_d", 32'(ram8.d), 32'(e.d[7:0]));
                chk("u8_be", 32'(ram8.be), 32'(e.be[0]));
            end
        end
        if (ram16.wr && !p16) begin
            nchk++;
            assert (q16.size() > 0) npass++;
            else $error("FAIL u16_unexpected_wr got a=%0h d=%0h exp none", ram16.a, ram16.d);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("u16_a", 32'(ram16.a), 32'(e.a));
                chk("u16_d", 32'(ram16.d & e.dm), 32'(e.d & e.dm));
                chk("u16_be", 32'(ram16.be), 32'(e.be));
            end
        end
        ram8.wr_ack  = ack_en && ram8.wr && p8;
        ram16.wr_ack = ack_en && ram16.wr && p16;
        p8  = ram8.wr;
        p16 = ram16.wr;
    end

    task automatic exp8(input logic [24:0] a, input logic [7:0] d);
        q8.push_back('{a: a, d: {8'h00, d}, dm: 16'h00FF, be: 2'b01});
    endtask
    task automatic exp16(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        q16.push_back('{a: a, d: d, dm: (be == 2'b11) ? 16'hFFFF : 16'h00FF, be: be});
    endtask

    task automatic spi_bit(input logic b);
        sdi = b;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask
    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask
    task automatic begin_cmd(input logic [7:0] c);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(c);
    endtask
    task automatic end_cmd();
        repeat (2) @(negedge clk);
        ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask
    task automatic cmd1(input logic [7:0] c, input logic [7:0] p);
        begin_cmd(c);
        spi_byte(p);
        end_cmd();
    endtask

    task automatic wait_idle(input string tag);
        logic done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            done = !dl8 && !dl16 && !ram8.wr && !ram16.wr && q8.size() == 0 && q16.size() == 0;
            if (!done) @(negedge clk);
        end
        nchk++;
        assert (done) npass++;
        else $error("FAIL %s drain timeout got q8=%0d q16=%0d exp 0", tag, q8.size(), q16.size());
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk);
        chk("rst_dl8", 32'(dl8), 0);        chk("rst_dl16", 32'(dl16), 0);
        chk("rst_size8", 32'(size8), 0);    chk("rst_idx8", 32'(idx8), 0);
        chk("rst_ov8", 32'(ov8), 0);        chk("rst_wr8", 32'(ram8.wr), 0);
        chk("rst_a8", 32'(ram8.a), 0);      chk("rst_d16", 32'(ram16.d), 0);
        chk("rst_be16", 32'(ram16.be), 0);
        reset = 1'b0;
        ack_en = 1'b1;
        repeat (4) @(negedge clk);

        // basic download: AA BB CC
        cmd1(8'h53, 8'h01);
        chk("t1_dl8", 32'(dl8), 1);         chk("t1_dl16", 32'(dl16), 1);
        exp8(0, 8'hAA); exp8(1, 8'hBB); exp8(2, 8'hCC);
        exp16(0, 16'hBBAA, 2'b11); exp16(2, 16'h00CC, 2'b01);
        begin_cmd(8'h54);
        spi_byte(8'hAA); spi_byte(8'hBB); spi_byte(8'hCC);
        end_cmd();
        cmd1(8'h53, 8'h00);
        wait_idle("t1");
        chk("t1_size8", 32'(size8), 3);     chk("t1_size16", 32'(size16), 3);
        chk("t1_ov8", 32'(ov8), 0);

        // index and data while idle
        cmd1(8'h55, 8'h9C);
        chk("t4_idx8", 32'(idx8), 32'h9C);  chk("t4_idx16", 32'(idx16), 32'h9C);
        begin_cmd(8'h54);
        spi_byte(8'h01); spi_byte(8'h02);
        end_cmd();
        repeat (10) @(negedge clk);
        chk("t4_size8", 32'(size8), 3);     chk("t4_size16", 32'(size16), 3);
        chk("t4_dl8", 32'(dl8), 0);

        // overflow with RAM stalled: 12 bytes, 4 words survive in each instance
        ack_en = 1'b0;
        cmd1(8'h53, 8'h01);
        for (int i = 0; i < 4; i++) exp8(25'(i), 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++)
            exp16(25'(2 * i), {8'h31 + 8'(2 * i), 8'h30 + 8'(2 * i)}, 2'b11);
        begin_cmd(8'h54);
        for (int i = 0; i < 12; i++) spi_byte(8'h30 + 8'(i));
        end_cmd();
        chk("t3_ov8", 32'(ov8), 1);         chk("t3_ov16", 32'(ov16), 1);
        chk("t3_size8", 32'(size8), 12);    chk("t3_size16", 32'(size16), 12);
        ack_en = 1'b1;
        cmd1(8'h53, 8'h00);
        wait_idle("t3");

        // restart with a write pending and words queued
        ack_en = 1'b0;
        cmd1(8'h53, 8'h01);
        exp8(0, 8'h40);
        exp16(0, 16'h4140, 2'b11);
        begin_cmd(8'h54);
        for (int i = 0; i < 6; i++) spi_byte(8'h40 + 8'(i));
        end_cmd();
        chk("t6_wr8", 32'(ram8.wr), 1);     chk("t6_wr16", 32'(ram16.wr), 1);
        cmd1(8'h53, 8'h01);
        chk("t6_ov8", 32'(ov8), 0);         chk("t6_size8", 32'(size8), 0);
        ack_en = 1'b1;
        for (int i = 0; i < 4; i++) exp8(25'(i), 8'h50 + 8'(i));
        exp16(0, 16'h5150, 2'b11); exp16(2, 16'h5352, 2'b11);
        begin_cmd(8'h54);
        for (int i = 0; i < 4; i++) spi_byte(8'h50 + 8'(i));
        end_cmd();
        cmd1(8'h53, 8'h00);
        wait_idle("t6");
        chk("t6_size16", 32'(size16), 4);

        // reset in the middle of a byte, SPI keeps clocking with ss low
        cmd1(8'h53, 8'h01);
        exp8(0, 8'h60);
        begin_cmd(8'h54);
        spi_byte(8'h60);
        b = 8'h61;
        for (int i = 7; i >= 4; i--) spi_bit(b[i]);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 3; i >= 0; i--) spi_bit(b[i]);
        spi_byte(8'h62); spi_byte(8'h63);
        chk("t5_dl8", 32'(dl8), 0);         chk("t5_dl16", 32'(dl16), 0);
        chk("t5_size8", 32'(size8), 0);     chk("t5_size16", 32'(size16), 0);
        end_cmd();
        cmd1(8'h53, 8'h01);
        exp8(0, 8'h70); exp8(1, 8'h71);
        exp16(0, 16'h7170, 2'b11);
        begin_cmd(8'h54);
        spi_byte(8'h70); spi_byte(8'h71);
        end_cmd();
        cmd1(8'h53, 8'h00);
        wait_idle("t5");
        chk("t5_size8b", 32'(size8), 2);    chk("t5_size16b", 32'(size16), 2);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
